// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared sizes, PC address and source select type
package regfile_write_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 16;

    // R15 is the PC: writes to it go to the PC-load port and it is never tracked
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = 4'd15;

    // Which writeback source the round-robin pointer currently favours
    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } src_sel_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rtl/regfile_write_arbiter_rr_arbiter2.sv - two-way round-robin / fixed-priority grant
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   en_i                  0 suppresses all grants (flush)
//   alu_req_i, mem_req_i  requests
//   alu_gnt_o, mem_gnt_o  one-hot (or zero) grant, combinational
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
#(
    parameter int MEM_PRIORITY = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic alu_req_i,
    input  logic mem_req_i,
    output logic alu_gnt_o,
    output logic mem_gnt_o
);

    src_sel_e ptr_q, ptr_d;

    always_comb begin
        alu_gnt_o = 1'b0;
        mem_gnt_o = 1'b0;
        ptr_d     = ptr_q;
        if (en_i) begin
            if (alu_req_i && mem_req_i) begin
                // Pointer only moves on a real conflict, so a lone requester
                // does not steal the other side's next turn.
                if (MEM_PRIORITY != 0) begin
                    mem_gnt_o = 1'b1;
                end else if (ptr_q == SEL_ALU) begin
                    alu_gnt_o = 1'b1;
                    ptr_d     = SEL_MEM;
                end else begin
                    mem_gnt_o = 1'b1;
                    ptr_d     = SEL_ALU;
                end
            end else begin
                alu_gnt_o = alu_req_i;
                mem_gnt_o = mem_req_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= SEL_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between ALU and load writeback
//
// Ports:
//   clk_in, rst_in                         clock, async active-high reset
//   flush_in                               clear scoreboard, block grants this cycle
//   issue_en_in/issue_add_in/rd_add*_in    issuing instruction (dest, sources)
//   stall_out                              RAW/WAW hazard on the issuing instruction
//   alu_valid_in/alu_add_in/alu_data_in    ALU writeback request, alu_ready_out grant
//   mem_valid_in/mem_add_in/mem_data_in    load writeback request, mem_ready_out grant
//   write_en_out/write_add_out/write_data_out  registered register-file write
//   pc_load_out/pc_data_out                registered PC load (writes to R15)
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH_P = DATA_WIDTH,
    parameter int MEM_PRIORITY = 0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    flush_in,
    input  logic                    issue_en_in,
    input  logic [ADDR_WIDTH-1:0]   issue_add_in,
    input  logic [ADDR_WIDTH-1:0]   rd_addA_in,
    input  logic [ADDR_WIDTH-1:0]   rd_addB_in,
    output logic                    stall_out,
    input  logic                    alu_valid_in,
    input  logic [ADDR_WIDTH-1:0]   alu_add_in,
    input  logic [DATA_WIDTH_P-1:0] alu_data_in,
    output logic                    alu_ready_out,
    input  logic                    mem_valid_in,
    input  logic [ADDR_WIDTH-1:0]   mem_add_in,
    input  logic [DATA_WIDTH_P-1:0] mem_data_in,
    output logic                    mem_ready_out,
    output logic                    write_en_out,
    output logic [ADDR_WIDTH-1:0]   write_add_out,
    output logic [DATA_WIDTH_P-1:0] write_data_out,
    output logic                    pc_load_out,
    output logic [DATA_WIDTH_P-1:0] pc_data_out
);

    logic [NUM_REGS-1:0]     sb_q, sb_d;
    logic                    write_en_q, write_en_d;
    logic [ADDR_WIDTH-1:0]   write_add_q, write_add_d;
    logic [DATA_WIDTH_P-1:0] write_data_q, write_data_d;
    logic                    pc_load_q, pc_load_d;
    logic [DATA_WIDTH_P-1:0] pc_data_q, pc_data_d;

    logic                    alu_gnt, mem_gnt;
    logic [ADDR_WIDTH-1:0]   gnt_add;
    logic [DATA_WIDTH_P-1:0] gnt_data;
    logic                    hit_a, hit_b, hit_d;

    rr_arbiter2 #(
        .MEM_PRIORITY (MEM_PRIORITY)
    ) u_arb (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .en_i      (!flush_in),
        .alu_req_i (alu_valid_in),
        .mem_req_i (mem_valid_in),
        .alu_gnt_o (alu_gnt),
        .mem_gnt_o (mem_gnt)
    );

    assign alu_ready_out = alu_gnt;
    assign mem_ready_out = mem_gnt;

    // Hazard detect: R15 is never tracked, so it must never match
    always_comb begin
        hit_a     = (rd_addA_in   != PC_ADDR) && sb_q[rd_addA_in];
        hit_b     = (rd_addB_in   != PC_ADDR) && sb_q[rd_addB_in];
        hit_d     = (issue_add_in != PC_ADDR) && sb_q[issue_add_in];
        stall_out = issue_en_in && (hit_a || hit_b || hit_d);
    end

    assign gnt_add  = mem_gnt ? mem_add_in  : alu_add_in;
    assign gnt_data = mem_gnt ? mem_data_in : alu_data_in;

    always_comb begin
        write_en_d   = 1'b0;
        pc_load_d    = 1'b0;
        write_add_d  = write_add_q;
        write_data_d = write_data_q;
        pc_data_d    = pc_data_q;
        if (alu_gnt || mem_gnt) begin
            if (gnt_add == PC_ADDR) begin
                pc_load_d = 1'b1;
                pc_data_d = gnt_data;
            end else begin
                write_en_d   = 1'b1;
                write_add_d  = gnt_add;
                write_data_d = gnt_data;
            end
        end
    end

    // Clear on commit first, then set on issue, so a same-edge set wins
    // (the bit now belongs to the newly issued instruction).
    always_comb begin
        sb_d = sb_q;
        if (write_en_q) begin
            sb_d[write_add_q] = 1'b0;
        end
        if (issue_en_in && !stall_out && (issue_add_in != PC_ADDR)) begin
            sb_d[issue_add_in] = 1'b1;
        end
        if (flush_in) begin
            sb_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sb_q         <= '0;
            write_en_q   <= 1'b0;
            write_add_q  <= '0;
            write_data_q <= '0;
            pc_load_q    <= 1'b0;
            pc_data_q    <= '0;
        end else begin
            sb_q         <= sb_d;
            write_en_q   <= write_en_d;
            write_add_q  <= write_add_d;
            write_data_q <= write_data_d;
            pc_load_q    <= pc_load_d;
            pc_data_q    <= pc_data_d;
        end
    end

    assign write_en_out   = write_en_q;
    assign write_add_out  = write_add_q;
    assign write_data_out = write_data_q;
    assign pc_load_out    = pc_load_q;
    assign pc_data_out    = pc_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        issue_en_in;
    logic [3:0]  issue_add_in, rd_addA_in, rd_addB_in;
    logic        alu_valid_in, mem_valid_in;
    logic [3:0]  alu_add_in, mem_add_in;
    logic [31:0] alu_data_in, mem_data_in;

    logic        stall_out, alu_ready_out, mem_ready_out;
    logic        write_en_out, pc_load_out;
    logic [3:0]  write_add_out;
    logic [31:0] write_data_out, pc_data_out;

    logic        p_stall, p_alu_rdy, p_mem_rdy, p_wen, p_pcl;
    logic [3:0]  p_wadd;
    logic [31:0] p_wdata, p_pcdata;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          pc;
        logic [3:0]  add;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.MEM_PRIORITY(0)) dut (
        .clk_in(clk), .rst_in(rst_in), .flush_in(flush_in),
        .issue_en_in(issue_en_in), .issue_add_in(issue_add_in),
        .rd_addA_in(rd_addA_in), .rd_addB_in(rd_addB_in), .stall_out(stall_out),
        .alu_valid_in(alu_valid_in), .alu_add_in(alu_add_in), .alu_data_in(alu_data_in),
        .alu_ready_out(alu_ready_out),
        .mem_valid_in(mem_valid_in), .mem_add_in(mem_add_in), .mem_data_in(mem_data_in),
        .mem_ready_out(mem_ready_out),
        .write_en_out(write_en_out), .write_add_out(write_add_out),
        .write_data_out(write_data_out), .pc_load_out(pc_load_out), .pc_data_out(pc_data_out)
    );

    regfile_write_arbiter #(.MEM_PRIORITY(1)) dut_p (
        .clk_in(clk), .rst_in(rst_in), .flush_in(flush_in),
        .issue_en_in(issue_en_in), .issue_add_in(issue_add_in),
        .rd_addA_in(rd_addA_in), .rd_addB_in(rd_addB_in), .stall_out(p_stall),
        .alu_valid_in(alu_valid_in), .alu_add_in(alu_add_in), .alu_data_in(alu_data_in),
        .alu_ready_out(p_alu_rdy),
        .mem_valid_in(mem_valid_in), .mem_add_in(mem_add_in), .mem_data_in(mem_data_in),
        .mem_ready_out(p_mem_rdy),
        .write_en_out(p_wen), .write_add_out(p_wadd),
        .write_data_out(p_wdata), .pc_load_out(p_pcl), .pc_data_out(p_pcdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit pc, input logic [3:0] add, input logic [31:0] data);
        exp_t e;
        e.pc = pc;
        e.add = add;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every registered write/PC-load must match the next expected item
    always @(negedge clk) begin
        if (!rst_in && (write_en_out || pc_load_out)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {31'd0, write_en_out}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_pc_load", {31'd0, pc_load_out}, {31'd0, e.pc});
                chk("mon_write_en", {31'd0, write_en_out}, {31'd0, !e.pc});
                if (e.pc) begin
                    chk("mon_pc_data", pc_data_out, e.data);
                end else begin
                    chk("mon_write_add", {28'd0, write_add_out}, {28'd0, e.add});
                    chk("mon_write_data", write_data_out, e.data);
                end
            end
        end
    end

    initial begin
        rst_in = 1'b1; flush_in = 1'b0;
        issue_en_in = 1'b0; issue_add_in = 4'd0; rd_addA_in = 4'd0; rd_addB_in = 4'd0;
        alu_valid_in = 1'b0; alu_add_in = 4'd0; alu_data_in = 32'd0;
        mem_valid_in = 1'b0; mem_add_in = 4'd0; mem_data_in = 32'd0;
        cyc(); cyc();
        chk("rst_write_en", {31'd0, write_en_out}, 32'd0);
        chk("rst_pc_load", {31'd0, pc_load_out}, 32'd0);
        chk("rst_write_data", write_data_out, 32'd0);
        chk("rst_pc_data", pc_data_out, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        rst_in = 1'b0;
        cyc();

        // Lone ALU write
        alu_valid_in = 1'b1; alu_add_in = 4'd3; alu_data_in = 32'hDEADBEEF;
        #1;
        chk("alu_ready_lone", {30'd0, alu_ready_out, mem_ready_out}, 32'd2);
        push(0, 4'd3, 32'hDEADBEEF);
        cyc();
        alu_valid_in = 1'b0;

        // RAW stall on R5 until the cycle after its commit
        issue_en_in = 1'b1; issue_add_in = 4'd5; rd_addA_in = 4'd1; rd_addB_in = 4'd2;
        #1;
        chk("issue_r5_nostall", {31'd0, stall_out}, 32'd0);
        cyc();
        issue_add_in = 4'd6; rd_addA_in = 4'd5; rd_addB_in = 4'd0;
        alu_valid_in = 1'b1; alu_add_in = 4'd5; alu_data_in = 32'h55;
        #1;
        chk("raw_stall_1", {31'd0, stall_out}, 32'd1);
        chk("alu_ready_r5", {31'd0, alu_ready_out}, 32'd1);
        push(0, 4'd5, 32'h55);
        cyc();
        alu_valid_in = 1'b0;
        #1;
        chk("raw_stall_commit_cycle", {31'd0, stall_out}, 32'd1);
        cyc();
        chk("raw_stall_released", {31'd0, stall_out}, 32'd0);
        cyc();
        issue_en_in = 1'b0;

        // Load to R15 goes to the PC port; R15 never stalls
        mem_valid_in = 1'b1; mem_add_in = 4'd15; mem_data_in = 32'h100;
        issue_en_in = 1'b1; issue_add_in = 4'd15; rd_addA_in = 4'd15; rd_addB_in = 4'd15;
        #1;
        chk("mem_ready_pc", {30'd0, alu_ready_out, mem_ready_out}, 32'd1);
        chk("r15_nostall", {31'd0, stall_out}, 32'd0);
        push(1, 4'd15, 32'h100);
        cyc();
        mem_valid_in = 1'b0;
        #1;
        chk("r15_nostall_2", {31'd0, stall_out}, 32'd0);
        cyc();
        issue_en_in = 1'b0;

        // Conflicts: round-robin alternates; MEM_PRIORITY=1 copy always picks mem
        for (int i = 0; i < 4; i++) begin
            logic [3:0]  aa [4] = '{4'd3, 4'd4, 4'd4, 4'd8};
            logic [31:0] ad [4] = '{32'hA1, 32'hA2, 32'hA2, 32'hA3};
            logic [3:0]  ma [4] = '{4'd6, 4'd6, 4'd7, 4'd7};
            logic [31:0] md [4] = '{32'hB1, 32'hB1, 32'hB2, 32'hB2};
            alu_valid_in = 1'b1; alu_add_in = aa[i]; alu_data_in = ad[i];
            mem_valid_in = 1'b1; mem_add_in = ma[i]; mem_data_in = md[i];
            #1;
            if (i % 2 == 0) begin
                chk("rr_grant_alu", {30'd0, alu_ready_out, mem_ready_out}, 32'd2);
                push(0, aa[i], ad[i]);
            end else begin
                chk("rr_grant_mem", {30'd0, alu_ready_out, mem_ready_out}, 32'd1);
                push(0, ma[i], md[i]);
            end
            chk("prio_grant_mem", {30'd0, p_alu_rdy, p_mem_rdy}, 32'd1);
            cyc();
        end
        alu_valid_in = 1'b0; mem_valid_in = 1'b0;

        // Flush: scoreboard cleared, grants suppressed for that cycle
        issue_en_in = 1'b1; issue_add_in = 4'd2; rd_addA_in = 4'd0; rd_addB_in = 4'd0;
        #1;
        chk("issue_r2_nostall", {31'd0, stall_out}, 32'd0);
        cyc();
        issue_en_in = 1'b0; flush_in = 1'b1;
        alu_valid_in = 1'b1; alu_add_in = 4'd9; alu_data_in = 32'h99;
        #1;
        chk("flush_no_grant", {30'd0, alu_ready_out, mem_ready_out}, 32'd0);
        cyc();
        flush_in = 1'b0;
        issue_en_in = 1'b1; issue_add_in = 4'd10; rd_addA_in = 4'd2; rd_addB_in = 4'd6;
        #1;
        chk("after_flush_nostall", {31'd0, stall_out}, 32'd0);
        chk("after_flush_grant", {31'd0, alu_ready_out}, 32'd1);
        push(0, 4'd9, 32'h99);
        cyc();
        issue_en_in = 1'b0; alu_valid_in = 1'b0;

        // Same-edge commit and re-issue of R4: the bit stays set
        alu_valid_in = 1'b1; alu_add_in = 4'd4; alu_data_in = 32'h44;
        push(0, 4'd4, 32'h44);
        cyc();
        alu_valid_in = 1'b0;
        issue_en_in = 1'b1; issue_add_in = 4'd4; rd_addA_in = 4'd0; rd_addB_in = 4'd0;
        #1;
        chk("r4_reissue_nostall", {31'd0, stall_out}, 32'd0);
        cyc();
        issue_add_in = 4'd11; rd_addA_in = 4'd4;
        #1;
        chk("r4_still_set", {31'd0, stall_out}, 32'd1);
        cyc();
        chk("r4_still_set_2", {31'd0, stall_out}, 32'd1);
        issue_en_in = 1'b0;

        // Async reset while a write is on the outputs
        alu_valid_in = 1'b1; alu_add_in = 4'd12; alu_data_in = 32'hC0FFEE;
        cyc();
        alu_valid_in = 1'b0;
        chk("pre_rst_write_en", {31'd0, write_en_out}, 32'd1);
        #1;
        rst_in = 1'b1;
        issue_en_in = 1'b1; issue_add_in = 4'd10; rd_addA_in = 4'd4; rd_addB_in = 4'd4;
        #1;
        chk("async_rst_write_en", {31'd0, write_en_out}, 32'd0);
        chk("async_rst_write_data", write_data_out, 32'd0);
        chk("async_rst_stall", {31'd0, stall_out}, 32'd0);
        cyc();
        rst_in = 1'b0;
        #1;
        chk("post_rst_sb_clear", {31'd0, stall_out}, 32'd0);
        issue_en_in = 1'b0;
        cyc(); cyc();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
